// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared fighter state encodings and frame counter width
package fighter_pkg;

    // Width of the per-phase frame counter; all phase lengths are 1..15 frames.
    localparam int FR_W = 4;

    // Fighter state encodings shared with the sprite renderer and hit detection.
    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_BACKWARD     = 3'd1;
    localparam logic [2:0] S_FORWARD      = 3'd2;
    localparam logic [2:0] S_ATK_START    = 3'd3;
    localparam logic [2:0] S_ATK_ACTIVE   = 3'd4;
    localparam logic [2:0] S_ATK_RECOVERY = 3'd5;
    localparam logic [2:0] S_HITSTUN      = 3'd6;

    // States in which player inputs are ignored and the phase timer runs.
    function automatic logic is_busy_state(input logic [2:0] s);
        return (s >= S_ATK_START) && (s <= S_HITSTUN);
    endfunction

    // Encodings above S_HITSTUN are never entered on purpose.
    function automatic logic is_valid_state(input logic [2:0] s);
        return (s <= S_HITSTUN);
    endfunction

endpackage

// File: rtl/fighter_state_ctrl_phase_timer.sv
// rtl/fighter_state_ctrl_phase_timer.sv - frame-granular down-counter for attack and hitstun phases
module phase_timer
    import fighter_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_i,
    input  logic            load_i,
    input  logic [FR_W-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [FR_W-1:0] count_q;
    logic [FR_W-1:0] count_d;

    // Load wins over decrement; the counter only moves on frame ticks and saturates at zero.
    always_comb begin
        count_d = count_q;
        if (tick_i) begin
            if (load_i) begin
                count_d = load_val_i;
            end else if (dec_i && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fighter_state_ctrl.sv
// rtl/fighter_state_ctrl.sv - per-player move/attack sequencer driven by frame ticks
module fighter_state_ctrl
    import fighter_pkg::*;
#(
    parameter int STARTUP_FR   = 4,
    parameter int ACTIVE_FR    = 2,
    parameter int RECOVERY_FR  = 8,
    parameter int HITSTUN_FR   = 12,
    parameter int FACING_RIGHT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       got_hit,
    output logic [2:0] state,
    output logic       hitbox_en,
    output logic       busy
);

    // Counter reload values: a phase of N frames loads N-1 and leaves on the tick that finds zero.
    localparam logic [FR_W-1:0] STARTUP_LD  = FR_W'(STARTUP_FR - 1);
    localparam logic [FR_W-1:0] ACTIVE_LD   = FR_W'(ACTIVE_FR - 1);
    localparam logic [FR_W-1:0] RECOVERY_LD = FR_W'(RECOVERY_FR - 1);
    localparam logic [FR_W-1:0] HITSTUN_LD  = FR_W'(HITSTUN_FR - 1);

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic            hitbox_q;
    logic            hitbox_d;
    logic            busy_q;
    logic            busy_d;
    logic            btn_attack_q;
    logic            atk_pending_q;
    logic            atk_pending_d;
    logic            hit_pending_q;
    logic            hit_pending_d;

    logic            atk_edge;
    logic            hit_now;
    logic            atk_start;
    logic            fwd_btn;
    logic            back_btn;
    logic            tmr_load;
    logic [FR_W-1:0] tmr_load_val;
    logic            tmr_dec;
    logic            tmr_zero;

    assign atk_edge = btn_attack & ~btn_attack_q;
    // A hit arriving on the tick clock itself is honoured on that tick.
    assign hit_now  = hit_pending_q | got_hit;
    assign fwd_btn  = (FACING_RIGHT != 0) ? btn_right : btn_left;
    assign back_btn = (FACING_RIGHT != 0) ? btn_left  : btn_right;

    phase_timer u_phase_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_i     (frame_tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // State register plus registered outputs and input-edge/pending latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hitbox_q      <= 1'b0;
            busy_q        <= 1'b0;
            btn_attack_q  <= 1'b0;
            atk_pending_q <= 1'b0;
            hit_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hitbox_q      <= hitbox_d;
            busy_q        <= busy_d;
            btn_attack_q  <= btn_attack;
            atk_pending_q <= atk_pending_d;
            hit_pending_q <= hit_pending_d;
        end
    end

    // Next-state: resolve hit, phase timing, attack start and movement once per frame tick.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        atk_start    = 1'b0;
        if (frame_tick) begin
            if (!is_valid_state(state_q)) begin
                state_d = S_IDLE;
            end else if (hit_now) begin
                state_d      = S_HITSTUN;
                tmr_load     = 1'b1;
                tmr_load_val = HITSTUN_LD;
            end else if (busy_q) begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    case (state_q)
                        S_ATK_START: begin
                            state_d      = S_ATK_ACTIVE;
                            tmr_load     = 1'b1;
                            tmr_load_val = ACTIVE_LD;
                        end
                        S_ATK_ACTIVE: begin
                            state_d      = S_ATK_RECOVERY;
                            tmr_load     = 1'b1;
                            tmr_load_val = RECOVERY_LD;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end else if (atk_pending_q || atk_edge) begin
                state_d      = S_ATK_START;
                tmr_load     = 1'b1;
                tmr_load_val = STARTUP_LD;
                atk_start    = 1'b1;
            end else if (fwd_btn && !back_btn) begin
                state_d = S_FORWARD;
            end else if (back_btn && !fwd_btn) begin
                state_d = S_BACKWARD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Outputs and latches: decode flags from the next state so they line up with it.
    always_comb begin
        hitbox_d = (state_d == S_ATK_ACTIVE);
        busy_d   = is_busy_state(state_d);

        // A press seen during a busy stretch is dropped at the next tick, so nothing queues across an attack.
        if (frame_tick && busy_q) begin
            atk_pending_d = 1'b0;
        end else if (atk_start) begin
            atk_pending_d = 1'b0;
        end else if (atk_edge) begin
            atk_pending_d = 1'b1;
        end else begin
            atk_pending_d = atk_pending_q;
        end

        hit_pending_d = frame_tick ? 1'b0 : (hit_pending_q | got_hit);
    end

    assign state     = state_q;
    assign hitbox_en = hitbox_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// tb/tb_fighter_state_ctrl.sv - randomized and directed checks of fighter_state_ctrl against a frame-level model
module tb_fighter_state_ctrl;

    localparam int STARTUP_FR  = 4;
    localparam int ACTIVE_FR   = 2;
    localparam int RECOVERY_FR = 8;
    localparam int HITSTUN_FR  = 12;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic       got_hit;
    logic [2:0] state;
    logic       hitbox_en;
    logic       busy;

    int total;
    int bad;

    // Model: current phase and the number of frame ticks still to spend in it.
    int m_st;
    int m_rem;
    bit m_prev;
    bit m_atk;
    bit m_hit;

    fighter_state_ctrl #(
        .STARTUP_FR   (STARTUP_FR),
        .ACTIVE_FR    (ACTIVE_FR),
        .RECOVERY_FR  (RECOVERY_FR),
        .HITSTUN_FR   (HITSTUN_FR),
        .FACING_RIGHT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_attack (btn_attack),
        .got_hit    (got_hit),
        .state      (state),
        .hitbox_en  (hitbox_en),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st   = 0;
        m_rem  = 0;
        m_prev = 0;
        m_atk  = 0;
        m_hit  = 0;
    endfunction

    // One clock of the model, evaluated from the rules in terms of frames remaining.
    function automatic void model_clk(input bit tk, input bit l, input bit r, input bit a, input bit h);
        bit edge_now;
        bit was_busy;
        bit started;
        edge_now = a && !m_prev;
        was_busy = (m_st >= 3);
        started  = 0;
        if (tk) begin
            if (m_hit || h) begin
                m_st  = 6;
                m_rem = HITSTUN_FR;
            end else if (was_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_st == 3) begin
                        m_st  = 4;
                        m_rem = ACTIVE_FR;
                    end else if (m_st == 4) begin
                        m_st  = 5;
                        m_rem = RECOVERY_FR;
                    end else begin
                        m_st = 0;
                    end
                end
            end else if (m_atk || edge_now) begin
                m_st    = 3;
                m_rem   = STARTUP_FR;
                started = 1;
            end else if (r && !l) begin
                m_st = 2;
            end else if (l && !r) begin
                m_st = 1;
            end else begin
                m_st = 0;
            end
        end
        if (tk && was_busy)  m_atk = 0;
        else if (started)    m_atk = 0;
        else if (edge_now)   m_atk = 1;
        m_hit  = tk ? 0 : (m_hit || h);
        m_prev = a;
    endfunction

    task automatic step(input bit tk, input bit l, input bit r, input bit a, input bit h);
        @(negedge clk);
        frame_tick = tk;
        btn_left   = l;
        btn_right  = r;
        btn_attack = a;
        got_hit    = h;
        model_clk(tk, l, r, a, h);
        @(posedge clk);
        #1;
        chk("state", int'(state), m_st);
        chk("hitbox_en", int'(hitbox_en), (m_st == 4) ? 1 : 0);
        chk("busy", int'(busy), (m_st >= 3) ? 1 : 0);
    endtask

    // Three quiet clocks then a tick clock, buttons held for the whole frame.
    task automatic tick_frame(input bit l, input bit r, input bit a);
        for (int i = 0; i < 3; i++) step(0, l, r, a, 0);
        step(1, l, r, a, 0);
    endtask

    initial begin
        int n3;
        int n4;
        int n5;
        int nhb;
        bit rl;
        bit rr;
        bit ra;

        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_attack = 1'b0;
        got_hit    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_hitbox", int'(hitbox_en), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Movement: forward only, then both held.
        tick_frame(0, 1, 0);
        chk("fwd_state", int'(state), 2);
        tick_frame(1, 1, 0);
        chk("both_idle", int'(state), 0);
        tick_frame(1, 0, 0);
        chk("back_state", int'(state), 1);
        tick_frame(0, 0, 0);

        // One-clock attack pulse between ticks: phase lengths 4/2/8.
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        n3 = 0; n4 = 0; n5 = 0; nhb = 0;
        for (int i = 0; i < 15; i++) begin
            tick_frame(0, 0, 0);
            if (state == 3'd3) n3++;
            if (state == 3'd4) n4++;
            if (state == 3'd5) n5++;
            if (hitbox_en)     nhb++;
        end
        chk("startup_ticks", n3, STARTUP_FR);
        chk("active_ticks", n4, ACTIVE_FR);
        chk("recovery_ticks", n5, RECOVERY_FR);
        chk("hitbox_ticks", nhb, ACTIVE_FR);
        chk("after_attack", int'(state), 0);

        // Attack held through the whole attack does not retrigger.
        for (int i = 0; i < 20; i++) tick_frame(0, 0, 1);
        chk("held_no_retrigger", int'(state), 0);
        tick_frame(0, 0, 0);

        // Hit during startup, then a second hit that restarts hitstun.
        step(0, 0, 0, 1, 0);
        tick_frame(0, 0, 0);
        chk("startup_entered", int'(state), 3);
        step(0, 0, 0, 0, 1);
        tick_frame(0, 0, 0);
        chk("hit_from_startup", int'(state), 6);
        for (int i = 0; i < 5; i++) tick_frame(0, 0, 0);
        step(0, 0, 0, 0, 1);
        tick_frame(0, 0, 0);
        for (int i = 0; i < HITSTUN_FR - 1; i++) tick_frame(0, 0, 0);
        chk("hitstun_restarted", int'(state), 6);
        tick_frame(0, 0, 0);
        chk("hitstun_done", int'(state), 0);

        // Hit and attack edge in the same frame: hit wins.
        step(0, 0, 0, 1, 1);
        tick_frame(0, 0, 0);
        chk("hit_beats_attack", int'(state), 6);
        for (int i = 0; i < HITSTUN_FR; i++) tick_frame(0, 0, 0);
        chk("hit_beats_attack_end", int'(state), 0);

        // No ticks for 1000 clocks: state holds while buttons wander.
        tick_frame(0, 1, 0);
        for (int i = 0; i < 1000; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        chk("no_tick_hold", int'(state), 2);
        tick_frame(0, 0, 0);
        for (int i = 0; i < 16; i++) tick_frame(0, 0, 0);

        // Asynchronous reset in the middle of the active phase.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < STARTUP_FR + 1; i++) tick_frame(0, 0, 0);
        chk("active_before_reset", int'(state), 4);
        @(negedge clk);
        rst        = 1'b1;
        btn_attack = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_hitbox", int'(hitbox_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick_frame(0, 0, 0);
        chk("after_reset_tick", int'(state), 0);

        // Random traffic against the model.
        rl = 0; rr = 0; ra = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) rl = ~rl;
            if ($urandom_range(0, 7) == 0) rr = ~rr;
            if ($urandom_range(0, 5) == 0) ra = ~ra;
            step(($urandom_range(0, 3) == 0), rl, rr, ra, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
